// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared types and helpers for the IF/ID pipeline stage
package if_id_pkg;

   localparam int PC_W_DEF   = 32;
   localparam int INST_W_DEF = 32;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;

   // Bit offset of a lane inside a packed multi-lane beat
   function automatic int lane_lsb(input int lane, input int data_w);
      return lane * data_w;
   endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - fetch-side and decode-side beat signals of the IF/ID stage
interface if_id_stage_if #(
   parameter int PC_W   = if_id_pkg::PC_W_DEF,
   parameter int INST_W = if_id_pkg::INST_W_DEF,
   parameter int LANES  = 1
);
   localparam int DATA_W = PC_W + INST_W;

   logic [LANES-1:0]        in_valid_i;
   logic [LANES*DATA_W-1:0] in_data_i;
   logic                    in_ready_o;
   logic [LANES-1:0]        out_valid_o;
   logic [LANES*DATA_W-1:0] out_data_o;

   modport master (
      output in_valid_i, in_data_i,
      input  in_ready_o, out_valid_o, out_data_o
   );

   modport slave (
      input  in_valid_i, in_data_i,
      output in_ready_o, out_valid_o, out_data_o
   );
endinterface

// File: rtl/stage_slot.sv
// rtl/stage_slot.sv - one LANES-wide valid+data register with load, clear and zero-fill
module stage_slot
   import if_id_pkg::*;
#(
   parameter int PC_W          = PC_W_DEF,
   parameter int INST_W        = INST_W_DEF,
   parameter int LANES         = 1,
   parameter bit ZERO_ON_FLUSH = 1'b1
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              load_i,
   input  logic                              clear_i,
   input  logic [LANES-1:0]                  valid_i,
   input  logic [LANES*(PC_W+INST_W)-1:0]    data_i,
   output logic [LANES-1:0]                  valid_o,
   output logic [LANES*(PC_W+INST_W)-1:0]    data_o
);
   localparam int DATA_W = PC_W + INST_W;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o <= '0;
         data_o  <= '0;
      end else if (clear_i) begin
         valid_o <= '0;
         if (ZERO_ON_FLUSH) data_o <= '0;
      end else if (load_i) begin
         valid_o <= valid_i;
         // Invalid lanes inside a live beat are scrubbed so decode never sees stale fields
         for (int k = 0; k < LANES; k++) begin
            if (valid_i[k] || !ZERO_ON_FLUSH)
               data_o[lane_lsb(k, DATA_W) +: DATA_W] <= data_i[lane_lsb(k, DATA_W) +: DATA_W];
            else
               data_o[lane_lsb(k, DATA_W) +: DATA_W] <= '0;
         end
      end
   end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - elastic IF/ID stage: two-entry skid buffer, flush with cache-stall deferral
module if_id_stage
   import if_id_pkg::*;
#(
   parameter int PC_W          = PC_W_DEF,
   parameter int INST_W        = INST_W_DEF,
   parameter int LANES         = 1,
   parameter bit ZERO_ON_FLUSH = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   if_id_stage_if.slave bus,
   input  logic        hazard_stall_i,
   input  logic        cache_stall_i,
   input  logic        flush_i,
   output logic [31:0] bubble_cnt_o
);
   localparam int DATA_W = PC_W + INST_W;

   state_e      state_q;
   logic        flush_pend_q;
   logic        in_ready_q;
   logic [31:0] bubble_cnt_q;

   logic stall, accept, flush_go, freeze;
   logic out_load, out_clear, out_sel_skid, skid_load, skid_clear;
   logic [LANES-1:0]        skid_valid, out_valid_in;
   logic [LANES*DATA_W-1:0] skid_data, out_data_in;

   assign stall    = hazard_stall_i | cache_stall_i;
   assign accept   = in_ready_q & (|bus.in_valid_i);
   assign flush_go = (flush_i | flush_pend_q) & ~cache_stall_i;
   assign freeze   = (flush_i | flush_pend_q) & cache_stall_i;

   always_comb begin
      out_load     = 1'b0;
      out_clear    = 1'b0;
      out_sel_skid = 1'b0;
      skid_load    = 1'b0;
      skid_clear   = 1'b0;
      if (flush_go) begin
         out_clear  = 1'b1;
         skid_clear = 1'b1;
      end else if (!freeze) begin
         case (state_q)
            EMPTY: out_load = accept;
            FULL: begin
               if (!stall) begin
                  out_load  = accept;
                  out_clear = ~accept;
               end else begin
                  skid_load = accept;
               end
            end
            SKID: begin
               if (!stall) begin
                  out_load     = 1'b1;
                  out_sel_skid = 1'b1;
                  skid_clear   = 1'b1;
               end
            end
            default: ;
         endcase
      end
      out_valid_in = out_sel_skid ? skid_valid : bus.in_valid_i;
      out_data_in  = out_sel_skid ? skid_data  : bus.in_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= EMPTY;
         flush_pend_q <= 1'b0;
         in_ready_q   <= 1'b1;
         bubble_cnt_q <= '0;
      end else begin
         if (((bus.out_valid_o == '0) || stall) && (bubble_cnt_q != 32'hFFFF_FFFF))
            bubble_cnt_q <= bubble_cnt_q + 32'd1;

         if (flush_go) begin
            state_q      <= EMPTY;
            flush_pend_q <= 1'b0;
            in_ready_q   <= 1'b1;
         end else if (freeze) begin
            // Cache holds the pipe: remember the redirect and stop taking beats
            flush_pend_q <= 1'b1;
            in_ready_q   <= 1'b0;
         end else begin
            in_ready_q <= 1'b1;
            case (state_q)
               EMPTY: if (accept) state_q <= FULL;
               FULL: begin
                  if (!stall && !accept) state_q <= EMPTY;
                  else if (stall && accept) begin
                     state_q    <= SKID;
                     in_ready_q <= 1'b0;
                  end
               end
               SKID: begin
                  if (!stall) state_q <= FULL;
                  else        in_ready_q <= 1'b0;
               end
               default: state_q <= EMPTY;
            endcase
         end
      end
   end

   assign bus.in_ready_o = in_ready_q;
   assign bubble_cnt_o   = bubble_cnt_q;

   stage_slot #(
      .PC_W(PC_W), .INST_W(INST_W), .LANES(LANES), .ZERO_ON_FLUSH(ZERO_ON_FLUSH)
   ) u_out_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (out_load),
      .clear_i (out_clear),
      .valid_i (out_valid_in),
      .data_i  (out_data_in),
      .valid_o (bus.out_valid_o),
      .data_o  (bus.out_data_o)
   );

   stage_slot #(
      .PC_W(PC_W), .INST_W(INST_W), .LANES(LANES), .ZERO_ON_FLUSH(ZERO_ON_FLUSH)
   ) u_skid_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .valid_i (bus.in_valid_i),
      .data_i  (bus.in_data_i),
      .valid_o (skid_valid),
      .data_o  (skid_data)
   );

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed vector table, random run against a queue model, counter saturation
module tb_if_id_stage;
   localparam int PC_W = 32, INST_W = 32, LANES = 2, BW = 128;

   logic clk = 1'b0;
   logic rst, hz, cs, fl;
   logic [31:0] bub;
   always #5 clk = ~clk;

   if_id_stage_if #(.PC_W(PC_W), .INST_W(INST_W), .LANES(LANES)) bus ();

   if_id_stage #(
      .PC_W(PC_W), .INST_W(INST_W), .LANES(LANES), .ZERO_ON_FLUSH(1'b1)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .bus            (bus.slave),
      .hazard_stall_i (hz),
      .cache_stall_i  (cs),
      .flush_i        (fl),
      .bubble_cnt_o   (bub)
   );

   int n_chk = 0;
   int n_pass = 0;

   typedef struct {
      logic        rst;
      logic [1:0]  vld;
      logic [31:0] pc;
      logic        hz, cs, fl;
      logic        erdy;
      logic [1:0]  evld;
      logic [31:0] epc;
      logic [31:0] ebub;
   } vec_t;

   typedef struct {
      logic [1:0]    v;
      logic [BW-1:0] d;
   } beat_t;

   vec_t  tbl[28];
   beat_t mq[$];

   function automatic logic [BW-1:0] mk(input logic [31:0] pc);
      return {pc + 32'd4, 32'h2000_0000 | pc, pc, 32'h1000_0000 | pc};
   endfunction

   function automatic logic [BW-1:0] mask(input logic [1:0] v, input logic [BW-1:0] d);
      logic [BW-1:0] r;
      r = d;
      if (!v[0]) r[63:0]   = '0;
      if (!v[1]) r[127:64] = '0;
      return r;
   endfunction

   function automatic vec_t v(input logic r, input logic [1:0] vl, input logic [31:0] pc,
                              input logic h, input logic c, input logic f,
                              input logic er, input logic [1:0] ev, input logic [31:0] ep,
                              input logic [31:0] eb);
      vec_t t;
      t.rst = r; t.vld = vl; t.pc = pc; t.hz = h; t.cs = c; t.fl = f;
      t.erdy = er; t.evld = ev; t.epc = ep; t.ebub = eb;
      return t;
   endfunction

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   logic [1:0]    r_vld, m_curv;
   logic [BW-1:0] r_data;
   logic          m_pend, m_rdy, m_acc;
   logic [31:0]   m_bub;

   initial begin
      rst = 1'b1; hz = 1'b0; cs = 1'b0; fl = 1'b0;
      bus.in_valid_i = '0; bus.in_data_i = '0;

      //            rst vld   pc     hz cs fl  rdy evld epc    bub
      tbl[0]  = v(1, 2'b00, 0,      0, 0, 0,  1, 2'b00, 0,      0);
      tbl[1]  = v(0, 2'b11, 'h100,  0, 0, 0,  1, 2'b11, 'h100,  1);
      tbl[2]  = v(0, 2'b11, 'h108,  0, 0, 0,  1, 2'b11, 'h108,  1);
      tbl[3]  = v(0, 2'b11, 'h110,  0, 0, 0,  1, 2'b11, 'h110,  1);
      tbl[4]  = v(0, 2'b11, 'h118,  0, 0, 0,  1, 2'b11, 'h118,  1);
      tbl[5]  = v(0, 2'b11, 'h10,   0, 0, 0,  1, 2'b11, 'h10,   1);
      tbl[6]  = v(0, 2'b11, 'h14,   1, 0, 0,  0, 2'b11, 'h10,   2);
      tbl[7]  = v(0, 2'b11, 'h18,   1, 0, 0,  0, 2'b11, 'h10,   3);
      tbl[8]  = v(0, 2'b11, 'h18,   1, 0, 0,  0, 2'b11, 'h10,   4);
      tbl[9]  = v(0, 2'b11, 'h18,   0, 0, 0,  1, 2'b11, 'h14,   4);
      tbl[10] = v(0, 2'b11, 'h18,   0, 0, 0,  1, 2'b11, 'h18,   4);
      tbl[11] = v(0, 2'b00, 0,      0, 0, 0,  1, 2'b00, 0,      4);
      tbl[12] = v(0, 2'b00, 0,      0, 0, 0,  1, 2'b00, 0,      5);
      tbl[13] = v(0, 2'b01, 'h20,   0, 0, 0,  1, 2'b01, 'h20,   6);
      tbl[14] = v(0, 2'b11, 'h30,   1, 0, 1,  1, 2'b00, 0,      7);
      tbl[15] = v(0, 2'b00, 0,      0, 0, 0,  1, 2'b00, 0,      8);
      tbl[16] = v(0, 2'b11, 'h40,   0, 0, 0,  1, 2'b11, 'h40,   9);
      tbl[17] = v(0, 2'b00, 0,      0, 1, 1,  0, 2'b11, 'h40,   10);
      tbl[18] = v(0, 2'b00, 0,      0, 1, 0,  0, 2'b11, 'h40,   11);
      tbl[19] = v(0, 2'b00, 0,      0, 1, 0,  0, 2'b11, 'h40,   12);
      tbl[20] = v(0, 2'b00, 0,      0, 1, 0,  0, 2'b11, 'h40,   13);
      tbl[21] = v(0, 2'b00, 0,      0, 1, 0,  0, 2'b11, 'h40,   14);
      tbl[22] = v(0, 2'b00, 0,      0, 0, 0,  1, 2'b00, 0,      14);
      tbl[23] = v(0, 2'b00, 0,      0, 0, 0,  1, 2'b00, 0,      15);
      tbl[24] = v(0, 2'b11, 'h50,   0, 0, 0,  1, 2'b11, 'h50,   16);
      tbl[25] = v(0, 2'b11, 'h58,   1, 0, 0,  0, 2'b11, 'h50,   17);
      tbl[26] = v(1, 2'b11, 'h60,   0, 0, 0,  1, 2'b00, 0,      0);
      tbl[27] = v(0, 2'b00, 0,      0, 0, 0,  1, 2'b00, 0,      1);

      for (int i = 0; i < 28; i++) begin
         rst = tbl[i].rst; hz = tbl[i].hz; cs = tbl[i].cs; fl = tbl[i].fl;
         bus.in_valid_i = tbl[i].vld;
         bus.in_data_i  = mk(tbl[i].pc);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_ready", i), BW'(bus.in_ready_o), BW'(tbl[i].erdy));
         chk($sformatf("vec%0d_valid", i), BW'(bus.out_valid_o), BW'(tbl[i].evld));
         chk($sformatf("vec%0d_data", i), bus.out_data_o, mask(tbl[i].evld, mk(tbl[i].epc)));
         chk($sformatf("vec%0d_bubble", i), BW'(bub), BW'(tbl[i].ebub));
      end

      // Random traffic against a two-deep queue model of the stage
      m_pend = 1'b0; m_rdy = 1'b1; m_bub = '0;
      for (int i = 0; i < 400; i++) begin
         rst    = (i == 0) || ($urandom_range(0, 63) == 0);
         hz     = ($urandom_range(0, 3) == 0);
         cs     = ($urandom_range(0, 4) == 0);
         fl     = ($urandom_range(0, 11) == 0);
         r_vld  = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
         r_data = {$urandom, $urandom, $urandom, $urandom};
         bus.in_valid_i = r_vld;
         bus.in_data_i  = r_data;

         if (rst) begin
            mq.delete(); m_pend = 1'b0; m_rdy = 1'b1; m_bub = '0;
         end else begin
            m_curv = (mq.size() > 0) ? mq[0].v : 2'b00;
            if ((m_curv == 2'b00 || hz || cs) && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
            if ((fl || m_pend) && !cs) begin
               mq.delete(); m_pend = 1'b0;
            end else if (fl || m_pend) begin
               m_pend = 1'b1;
            end else begin
               m_acc = m_rdy && (r_vld != 2'b00);
               if (mq.size() > 0 && !(hz || cs)) void'(mq.pop_front());
               if (m_acc) mq.push_back('{r_vld, mask(r_vld, r_data)});
            end
            m_rdy = (mq.size() < 2) && !m_pend;
         end

         @(posedge clk); #1;
         chk($sformatf("rand%0d_ready", i), BW'(bus.in_ready_o), BW'(m_rdy));
         chk($sformatf("rand%0d_valid", i), BW'(bus.out_valid_o),
             BW'((mq.size() > 0) ? mq[0].v : 2'b00));
         chk($sformatf("rand%0d_data", i), bus.out_data_o,
             (mq.size() > 0) ? mq[0].d : '0);
         chk($sformatf("rand%0d_bubble", i), BW'(bub), BW'(m_bub));
      end

      // Bubble counter saturation from a preloaded near-max value
      rst = 1'b1; hz = 1'b0; cs = 1'b0; fl = 1'b0; bus.in_valid_i = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      force dut.bubble_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.bubble_cnt_q;
      @(posedge clk); #1;
      chk("sat_reach", BW'(bub), BW'(32'hFFFF_FFFF));
      @(posedge clk); #1;
      chk("sat_hold", BW'(bub), BW'(32'hFFFF_FFFF));
      @(posedge clk); #1;
      chk("sat_no_wrap", BW'(bub), BW'(32'hFFFF_FFFF));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
